// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU plus a multi-cycle radix-2 restoring divider.
// While a divide is in flight, stall_req freezes the front end and the write enables are held off.
module ex_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_regfile_we,
  input  logic [4:0]  ex_regfile_waddr,
  input  logic [7:0]  ex_alu_op,
  input  logic [31:0] ex_alu_src1,
  input  logic [31:0] ex_alu_src2,
  input  logic        ex_mem_re,
  input  logic        ex_mem_we,
  output logic        out_regfile_we,
  output logic        out_mem_re,
  output logic        out_mem_we,
  output logic [4:0]  out_regfile_waddr,
  output logic [31:0] out_wdata,
  output logic        stall_req
);

  localparam logic [7:0] OP_NOP  = 8'h00, OP_ADD  = 8'h01, OP_SUB  = 8'h02, OP_AND  = 8'h03,
                         OP_OR   = 8'h04, OP_XOR  = 8'h05, OP_SLT  = 8'h06, OP_SLTU = 8'h07,
                         OP_SLL  = 8'h08, OP_SRL  = 8'h09, OP_SRA  = 8'h0A, OP_DIV  = 8'h0B,
                         OP_DIVU = 8'h0C, OP_REM  = 8'h0D, OP_REMU = 8'h0E;

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   dvd_q, dvd_d;     // dividend shifts out, quotient bits shift in
  logic [31:0]   dvs_q, dvs_d;
  logic [31:0]   prem_q, prem_d;
  logic [31:0]   quot_q, quot_d;
  logic [31:0]   rem_q, rem_d;
  logic          negq_q, negq_d, negr_q, negr_d;

  logic        is_div, is_signed, want_rem, stall_raw, en_ok;
  logic [31:0] alu_res, a_mag, b_mag, dvd_n, prem_n;
  logic [32:0] rem_sh, diff;

  always_comb begin
    alu_res = '0;
    case (ex_alu_op)
      OP_NOP:  alu_res = '0;
      OP_ADD:  alu_res = ex_alu_src1 + ex_alu_src2;
      OP_SUB:  alu_res = ex_alu_src1 - ex_alu_src2;
      OP_AND:  alu_res = ex_alu_src1 & ex_alu_src2;
      OP_OR:   alu_res = ex_alu_src1 | ex_alu_src2;
      OP_XOR:  alu_res = ex_alu_src1 ^ ex_alu_src2;
      OP_SLT:  alu_res = {31'b0, $signed(ex_alu_src1) < $signed(ex_alu_src2)};
      OP_SLTU: alu_res = {31'b0, ex_alu_src1 < ex_alu_src2};
      OP_SLL:  alu_res = ex_alu_src1 << ex_alu_src2[4:0];
      OP_SRL:  alu_res = ex_alu_src1 >> ex_alu_src2[4:0];
      OP_SRA:  alu_res = $unsigned($signed(ex_alu_src1) >>> ex_alu_src2[4:0]);
      default: alu_res = '0;
    endcase
  end

  assign is_div    = (ex_alu_op == OP_DIV) || (ex_alu_op == OP_DIVU) ||
                     (ex_alu_op == OP_REM) || (ex_alu_op == OP_REMU);
  assign is_signed = (ex_alu_op == OP_DIV) || (ex_alu_op == OP_REM);
  assign want_rem  = (ex_alu_op == OP_REM) || (ex_alu_op == OP_REMU);
  assign a_mag     = (is_signed && ex_alu_src1[31]) ? 32'd0 - ex_alu_src1 : ex_alu_src1;
  assign b_mag     = (is_signed && ex_alu_src2[31]) ? 32'd0 - ex_alu_src2 : ex_alu_src2;

  // One restoring step: trial-subtract the divisor from the shifted partial remainder.
  always_comb begin
    rem_sh = {prem_q, dvd_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!diff[32]) begin
      prem_n = diff[31:0];
      dvd_n  = {dvd_q[30:0], 1'b1};
    end else begin
      prem_n = rem_sh[31:0];
      dvd_n  = {dvd_q[30:0], 1'b0};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    prem_d    = prem_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    stall_raw = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_div && !flush) begin
          stall_raw = 1'b1;
          if (ex_alu_src2 == 32'd0) begin
            quot_d  = 32'hFFFF_FFFF;
            rem_d   = ex_alu_src1;
            state_d = S_DONE;
          end else begin
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            prem_d  = '0;
            negq_d  = is_signed && (ex_alu_src1[31] ^ ex_alu_src2[31]);
            negr_d  = is_signed && ex_alu_src1[31];
            cnt_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        stall_raw = 1'b1;
        dvd_d     = dvd_n;
        prem_d    = prem_n;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          quot_d  = negq_q ? 32'd0 - dvd_n : dvd_n;
          rem_d   = negr_q ? 32'd0 - prem_n : prem_n;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // Outputs are gated by reset so nothing leaks out while rst is held low.
  assign stall_req         = rst && stall_raw && !flush;
  assign en_ok             = rst && !stall_req && !flush;
  assign out_regfile_we    = en_ok && ex_regfile_we;
  assign out_mem_re        = en_ok && ex_mem_re;
  assign out_mem_we        = en_ok && ex_mem_we;
  assign out_regfile_waddr = ex_regfile_waddr;
  assign out_wdata         = !rst ? 32'd0 :
                             (state_q == S_DONE) ? (want_rem ? rem_q : quot_q) : alu_res;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, enable qualification, divider latency/results,
// flush and reset behaviour.
module tb_ex_stage;
  localparam logic [7:0] OP_NOP  = 8'h00, OP_ADD  = 8'h01, OP_SUB  = 8'h02, OP_AND  = 8'h03,
                         OP_OR   = 8'h04, OP_XOR  = 8'h05, OP_SLT  = 8'h06, OP_SLTU = 8'h07,
                         OP_SLL  = 8'h08, OP_SRL  = 8'h09, OP_SRA  = 8'h0A, OP_DIV  = 8'h0B,
                         OP_DIVU = 8'h0C, OP_REM  = 8'h0D, OP_REMU = 8'h0E;

  logic        clk = 0, rst = 0, flush = 0;
  logic        ex_regfile_we = 0, ex_mem_re = 0, ex_mem_we = 0;
  logic [4:0]  ex_regfile_waddr = 0;
  logic [7:0]  ex_alu_op = 0;
  logic [31:0] ex_alu_src1 = 0, ex_alu_src2 = 0;
  logic        out_regfile_we, out_mem_re, out_mem_we, stall_req;
  logic [4:0]  out_regfile_waddr;
  logic [31:0] out_wdata;
  int total = 0, bad = 0;

  ex_stage #(.DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_regfile_we(ex_regfile_we), .ex_regfile_waddr(ex_regfile_waddr),
    .ex_alu_op(ex_alu_op), .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2),
    .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
    .out_regfile_we(out_regfile_we), .out_mem_re(out_mem_re), .out_mem_we(out_mem_we),
    .out_regfile_waddr(out_regfile_waddr), .out_wdata(out_wdata), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_alu_op = op; ex_alu_src1 = a; ex_alu_src2 = b;
  endtask

  task automatic test_reset();
    set_op(OP_DIV, 32'd9, 32'd2);
    ex_regfile_we = 1; ex_mem_re = 1; ex_mem_we = 1;
    #3;
    total++;
    if ({stall_req, out_regfile_we, out_mem_re, out_mem_we} !== 4'b0000 || out_wdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: got stall/we/re/wr=%b%b%b%b wdata=%h want 0000 00000000",
               stall_req, out_regfile_we, out_mem_re, out_mem_we, out_wdata);
    end
    set_op(OP_NOP, 0, 0);
    ex_regfile_we = 0; ex_mem_re = 0; ex_mem_we = 0;
    next_cyc();
    rst = 1;
    next_cyc();
  endtask

  task automatic test_alu();
    logic [7:0]  ops [11] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU,
                              OP_SLL, OP_SRL, OP_SRA, OP_NOP};
    logic [31:0] as  [11] = '{32'd7, 32'd5, 32'hF0F0_1234, 32'hF000_0000, 32'hFFFF_0000,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000,
                              32'h8000_0000, 32'h1234_5678};
    logic [31:0] bs  [11] = '{32'hFFFF_FFFF, 32'd7, 32'h0FF0_FF00, 32'h0000_000F, 32'hFF00_FF00,
                              32'd1, 32'd1, 32'h24, 32'h4, 32'h4, 32'h9};
    logic [31:0] ex  [11] = '{32'd6, 32'hFFFF_FFFE, 32'h00F0_1200, 32'hF000_000F, 32'h00FF_FF00,
                              32'd1, 32'd0, 32'd16, 32'h0800_0000, 32'hF800_0000, 32'd0};
    for (int i = 0; i < 11; i++) begin
      set_op(ops[i], as[i], bs[i]);
      ex_regfile_we = 1; ex_regfile_waddr = 5'(i + 3); ex_mem_re = i[0]; ex_mem_we = ~i[0];
      #4;
      total++;
      if (out_wdata !== ex[i] || out_regfile_we !== 1'b1 || stall_req !== 1'b0 ||
          out_regfile_waddr !== 5'(i + 3) || out_mem_re !== i[0] || out_mem_we !== ~i[0]) begin
        bad++;
        $display("FAIL alu_op%0d: got wdata=%h we=%b stall=%b waddr=%0d want wdata=%h we=1 stall=0 waddr=%0d",
                 ops[i], out_wdata, out_regfile_we, stall_req, out_regfile_waddr, ex[i], i + 3);
      end
      next_cyc();
    end
  endtask

  task automatic test_flush_enables();
    set_op(OP_ADD, 32'd1, 32'd2);
    ex_regfile_we = 1; ex_mem_re = 1; ex_mem_we = 1; flush = 1;
    #4;
    total++;
    if ({out_regfile_we, out_mem_re, out_mem_we, stall_req} !== 4'b0000) begin
      bad++;
      $display("FAIL flush_enables: got we/re/wr/stall=%b%b%b%b want 0000",
               out_regfile_we, out_mem_re, out_mem_we, stall_req);
    end
    next_cyc();
    flush = 0; ex_mem_re = 0; ex_mem_we = 0;
  endtask

  // Presents a divide, counts stall cycles, checks the DONE-cycle result.
  task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_n,
                         input bit hold);
    int n = 0;
    bit done = 0;
    set_op(op, a, b);
    ex_regfile_we = 1; ex_regfile_waddr = 5'd9;
    for (int k = 0; k < 40 && !done; k++) begin
      #4;
      if (stall_req) begin
        total++;
        if (out_regfile_we !== 1'b0) begin
          bad++;
          $display("FAIL %s_we_in_stall: got we=%b want 0", nm, out_regfile_we);
        end
        n++;
        next_cyc();
      end else done = 1;
    end
    total++;
    if (!done || n != exp_n || out_wdata !== exp || out_regfile_we !== 1'b1) begin
      bad++;
      $display("FAIL %s: got stalls=%0d wdata=%h we=%b want stalls=%0d wdata=%h we=1",
               nm, n, out_wdata, out_regfile_we, exp_n, exp);
    end
    next_cyc();
    if (!hold) begin
      set_op(OP_NOP, 0, 0);
      ex_regfile_we = 0;
    end
  endtask

  task automatic test_div();
    run_div("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_div("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_div("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
    run_div("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    run_div("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    run_div("divu_big",   OP_DIVU, 32'hFFFF_FFFE, 32'd2, 32'h7FFF_FFFF, 33, 0);
  endtask

  task automatic test_div_boundaries();
    run_div("divu_by0",  OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_div("rem_by0",   OP_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1, 0);
    run_div("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 0);
    run_div("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 0);
  endtask

  task automatic test_back_to_back();
    run_div("b2b_first", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1);
    #4;
    total++;
    if (stall_req !== 1'b1) begin
      bad++;
      $display("FAIL b2b_restart: got stall=%b want 1", stall_req);
    end
    flush = 1;
    #1;
    total++;
    if (stall_req !== 1'b0 || out_regfile_we !== 1'b0) begin
      bad++;
      $display("FAIL b2b_flush: got stall=%b we=%b want 0 0", stall_req, out_regfile_we);
    end
    next_cyc();
    flush = 0; set_op(OP_NOP, 0, 0); ex_regfile_we = 0;
    next_cyc();
  endtask

  task automatic test_flush_busy();
    set_op(OP_DIV, 32'd1000, 32'd3);
    ex_regfile_we = 1;
    for (int k = 0; k < 10; k++) next_cyc();
    #2;
    total++;
    if (stall_req !== 1'b1) begin
      bad++;
      $display("FAIL flush_busy_pre: got stall=%b want 1", stall_req);
    end
    flush = 1;
    #1;
    total++;
    if (stall_req !== 1'b0 || out_regfile_we !== 1'b0) begin
      bad++;
      $display("FAIL flush_busy: got stall=%b we=%b want 0 0", stall_req, out_regfile_we);
    end
    next_cyc();
    flush = 0; set_op(OP_ADD, 32'd20, 32'd22);
    #4;
    total++;
    if (stall_req !== 1'b0 || out_wdata !== 32'd42 || out_regfile_we !== 1'b1) begin
      bad++;
      $display("FAIL flush_busy_after: got stall=%b wdata=%h we=%b want 0 0000002a 1",
               stall_req, out_wdata, out_regfile_we);
    end
    next_cyc();
  endtask

  task automatic test_flush_idle_div();
    set_op(OP_DIV, 32'd50, 32'd5);
    ex_regfile_we = 1; flush = 1;
    #4;
    total++;
    if (stall_req !== 1'b0 || out_regfile_we !== 1'b0) begin
      bad++;
      $display("FAIL flush_idle_div: got stall=%b we=%b want 0 0", stall_req, out_regfile_we);
    end
    next_cyc();
    flush = 0; set_op(OP_SUB, 32'd10, 32'd3);
    #4;
    total++;
    if (stall_req !== 1'b0 || out_wdata !== 32'd7) begin
      bad++;
      $display("FAIL flush_idle_nostart: got stall=%b wdata=%h want 0 00000007", stall_req, out_wdata);
    end
    next_cyc();
  endtask

  task automatic test_rst_mid();
    set_op(OP_DIV, 32'd77, 32'd7);
    ex_regfile_we = 1; ex_mem_re = 1;
    for (int k = 0; k < 5; k++) next_cyc();
    #2;
    rst = 0;
    #1;
    total++;
    if ({stall_req, out_regfile_we, out_mem_re, out_mem_we} !== 4'b0000 || out_wdata !== 32'd0) begin
      bad++;
      $display("FAIL rst_mid: got stall/we/re/wr=%b%b%b%b wdata=%h want 0000 00000000",
               stall_req, out_regfile_we, out_mem_re, out_mem_we, out_wdata);
    end
    next_cyc();
    set_op(OP_ADD, 32'd7, 32'hFFFF_FFFF); ex_mem_re = 0;
    #2;
    rst = 1;
    next_cyc();
    #3;
    total++;
    if (stall_req !== 1'b0 || out_wdata !== 32'd6 || out_regfile_we !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_add: got stall=%b wdata=%h we=%b want 0 00000006 1",
               stall_req, out_wdata, out_regfile_we);
    end
    for (int k = 0; k < 40; k++) begin
      next_cyc();
      #3;
      total++;
      if (stall_req !== 1'b0 || out_wdata !== 32'd6) begin
        bad++;
        $display("FAIL rst_mid_ghost: cycle %0d got stall=%b wdata=%h want 0 00000006",
                 k, stall_req, out_wdata);
      end
    end
    next_cyc();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_flush_enables();
    test_div();
    test_div_boundaries();
    test_back_to_back();
    test_flush_busy();
    test_flush_idle_div();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
